// File: rtl/light_input_conditioner.sv
// Switch front-end for the tail-light sequencer: 2-flop sync, per-channel debounce,
// tick prescaler and hazard>right>left resolve. Define STICKY_HAZARD_EN for a latching hazard.
module light_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICK_DIV        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_left,
    input  logic sw_right,
    input  logic sw_hazard,
    output logic tick,
    output logic a,
    output logic b,
    output logic c
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Channel order: [0] left, [1] right, [2] hazard.
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    stable;
    logic [2:0]    stable_n;
    logic [CW-1:0] cnt   [3];
    logic [CW-1:0] cnt_n [3];
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic          hz;
    logic          a_n;
    logic          b_n;
    logic          c_n;

    assign raw = {sw_hazard, sw_right, sw_left};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_n[i] = stable[i];
            cnt_n[i]    = '0;
            if (s2[i] != stable[i]) begin
                // Flip on the edge the count would reach DEBOUNCE_CYCLES.
                if (cnt[i] == DB_LAST) begin
                    stable_n[i] = s2[i];
                end else begin
                    cnt_n[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign tick   = (tcnt == TICK_LAST);
    assign tcnt_n = tick ? '0 : tcnt + 1'b1;

`ifdef STICKY_HAZARD_EN
    logic sticky;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky <= 1'b0;
        end else if (stable_n[2] && !stable[2]) begin
            sticky <= ~sticky;
        end
    end

    assign hz = sticky;
`else
    assign hz = stable[2];
`endif

    assign c_n = hz;
    assign b_n = stable[1] & ~hz;
    assign a_n = stable[0] & ~stable[1] & ~hz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            tcnt   <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            c      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= raw;
            s2     <= s1;
            stable <= stable_n;
            tcnt   <= tcnt_n;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_n[i];
            end
            // Loads the pre-edge stable values, so a same-edge flip waits one tick.
            if (tick) begin
                a <= a_n;
                b <= b_n;
                c <= c_n;
            end
        end
    end

endmodule
